// File: rtl/glm_c0_read_arbiter.sv
// glm_c0_read_arbiter: round-robin share of one CCI-P c0 read channel among NUM_REQ load engines.
// Define GLM_C0ARB_INFLIGHT_LIMIT_EN to cap outstanding read lines per requester.
package ccip_if_pkg;
   typedef struct packed {
      logic [1:0]  vc_sel;
      logic [1:0]  rsvd1;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [5:0]  rsvd0;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c0_ReqMemHdr;
   typedef struct packed {
      logic [1:0]  vc_used;
      logic        rsvd1;
      logic        hit_miss;
      logic [1:0]  rsvd0;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_c0_RspMemHdr;
   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;
   typedef struct packed {
      t_ccip_c0_RspMemHdr hdr;
      logic [511:0]       data;
      logic               rspValid;
      logic               mmioRdValid;
      logic               mmioWrValid;
   } t_if_ccip_c0_Rx;
   localparam logic [3:0] eRSP_RDLINE = 4'h0;
endpackage

module glm_c0_read_arbiter
   import ccip_if_pkg::*;
#(
   parameter int NUM_REQ            = 4,
   parameter int ID_BITS            = 2,
   parameter int LOG2_REQ_FIFO      = 3,
   parameter int ALMFULL_MARGIN     = 3,
   parameter int MAX_INFLIGHT_LINES = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               c0TxAlmFull,
   output t_if_ccip_c0_Tx     af2cp_sTx_c0,
   input  t_if_ccip_c0_Rx     cp2af_sRx_c0,
   input  t_if_ccip_c0_Tx     req_sTx_c0 [NUM_REQ],
   output logic [NUM_REQ-1:0] req_almfull,
   output t_if_ccip_c0_Rx     req_sRx_c0 [NUM_REQ],
   output logic [ID_BITS-1:0] grant_id
);
   localparam int DEPTH = 1 << LOG2_REQ_FIFO;
   localparam int CW    = LOG2_REQ_FIFO + 1;
   t_ccip_c0_ReqMemHdr       mem [NUM_REQ][DEPTH];
   t_ccip_c0_ReqMemHdr       head [NUM_REQ];
   t_ccip_c0_ReqMemHdr       tx_hdr;
   t_ccip_c0_RspMemHdr       rsp_hdr;
   logic [LOG2_REQ_FIFO-1:0] wr_ptr [NUM_REQ];
   logic [LOG2_REQ_FIFO-1:0] rd_ptr [NUM_REQ];
   logic [CW-1:0]            count [NUM_REQ];
   logic [CW-1:0]            cnt_nxt [NUM_REQ];
   logic [NUM_REQ-1:0]       push, pop, eligible;
   logic [ID_BITS-1:0]       rr_ptr, winner, idx, rx_id;
   logic                     any_win, rx_read, unused;
   assign rx_read = cp2af_sRx_c0.rspValid && cp2af_sRx_c0.hdr.resp_type == eRSP_RDLINE;
   assign rx_id   = cp2af_sRx_c0.hdr.mdata[15 -: ID_BITS];
`ifdef GLM_C0ARB_INFLIGHT_LIMIT_EN
   logic [15:0] inflight [NUM_REQ];
   assign unused = ^{cp2af_sRx_c0.mmioRdValid, cp2af_sRx_c0.mmioWrValid};
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++)
         inflight[i] <= reset ? '0 : inflight[i] + (pop[i] ? 16'(head[i].cl_len) + 16'd1 : 16'd0)
                        - 16'(rx_read && rx_id == ID_BITS'(i));
   end
`else
   assign unused = ^{cp2af_sRx_c0.mmioRdValid, cp2af_sRx_c0.mmioWrValid, 1'(MAX_INFLIGHT_LINES)};
`endif
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         head[i]     = mem[i][rd_ptr[i]];
         push[i]     = req_sTx_c0[i].valid && count[i] != CW'(DEPTH);
`ifdef GLM_C0ARB_INFLIGHT_LIMIT_EN
         eligible[i] = count[i] != '0 && !c0TxAlmFull &&
                       17'(inflight[i]) + 17'(head[i].cl_len) + 17'd1 <= 17'(MAX_INFLIGHT_LINES);
`else
         eligible[i] = count[i] != '0 && !c0TxAlmFull;
`endif
      end
   end
   // Scan offsets from far to near so the nearest eligible requester at or after rr_ptr wins.
   always_comb begin
      winner  = rr_ptr;
      any_win = 1'b0;
      idx     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = ID_BITS'((int'(rr_ptr) + k) % NUM_REQ);
         if (eligible[idx]) begin
            winner  = idx;
            any_win = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         pop[i]     = any_win && winner == ID_BITS'(i);
         cnt_nxt[i] = count[i] + CW'(push[i]) - CW'(pop[i]);
      end
      tx_hdr                      = head[winner];
      tx_hdr.mdata[15 -: ID_BITS] = winner;
      rsp_hdr                      = cp2af_sRx_c0.hdr;
      rsp_hdr.mdata[15 -: ID_BITS] = '0;
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++)
         if (push[i]) mem[i][wr_ptr[i]] <= req_sTx_c0[i].hdr;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         af2cp_sTx_c0 <= '0;
         grant_id     <= '0;
         rr_ptr       <= '0;
         req_almfull  <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            wr_ptr[i]     <= '0;
            rd_ptr[i]     <= '0;
            count[i]      <= '0;
            req_sRx_c0[i] <= '0;
         end
      end else begin
         af2cp_sTx_c0.valid <= any_win;
         if (any_win) begin
            af2cp_sTx_c0.hdr <= tx_hdr;
            grant_id         <= winner;
            rr_ptr           <= winner == ID_BITS'(NUM_REQ - 1) ? '0 : winner + 1'b1;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            wr_ptr[i]                <= wr_ptr[i] + LOG2_REQ_FIFO'(push[i]);
            rd_ptr[i]                <= rd_ptr[i] + LOG2_REQ_FIFO'(pop[i]);
            count[i]                 <= cnt_nxt[i];
            req_almfull[i]           <= cnt_nxt[i] >= CW'(DEPTH - ALMFULL_MARGIN);
            req_sRx_c0[i].rspValid   <= rx_read && rx_id == ID_BITS'(i);
            if (rx_read) begin
               req_sRx_c0[i].hdr  <= rsp_hdr;
               req_sRx_c0[i].data <= cp2af_sRx_c0.data;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++)
            assert (!(req_sTx_c0[i].valid && count[i] == CW'(DEPTH)));
         assert (!(rx_read && int'(rx_id) >= NUM_REQ));
      end
   end
endmodule

// File: tb/tb_glm_c0_read_arbiter.sv
// tb_glm_c0_read_arbiter: directed checks of issue order/timing, almost-full, steering and reset flush.
module tb_glm_c0_read_arbiter;
   import ccip_if_pkg::*;
   localparam int NR = 4;
`ifdef GLM_C0ARB_INFLIGHT_LIMIT_EN
   localparam int MAXL = 8;
`else
   localparam int MAXL = 64;
`endif
   logic           clk = 1'b0, reset = 1'b1, c0TxAlmFull = 1'b0;
   t_if_ccip_c0_Tx af2cp_sTx_c0;
   t_if_ccip_c0_Rx cp2af_sRx_c0;
   t_if_ccip_c0_Tx req_sTx_c0 [NR];
   logic [NR-1:0]  req_almfull;
   t_if_ccip_c0_Rx req_sRx_c0 [NR];
   logic [1:0]     grant_id;
   int             cyc = 0, vectors = 0, errors = 0, t0, r0;
   typedef struct {
      int          cyc;
      logic [41:0] addr;
      logic [15:0] md;
      logic [1:0]  gid;
   } iss_t;
   iss_t iss_q [$];

   glm_c0_read_arbiter #(.NUM_REQ(NR), .ID_BITS(2), .LOG2_REQ_FIFO(3), .ALMFULL_MARGIN(3),
                         .MAX_INFLIGHT_LINES(MAXL)) dut (
      .clk(clk), .reset(reset), .c0TxAlmFull(c0TxAlmFull), .af2cp_sTx_c0(af2cp_sTx_c0),
      .cp2af_sRx_c0(cp2af_sRx_c0), .req_sTx_c0(req_sTx_c0), .req_almfull(req_almfull),
      .req_sRx_c0(req_sRx_c0), .grant_id(grant_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (af2cp_sTx_c0.valid)
         iss_q.push_back('{cyc, af2cp_sTx_c0.hdr.address, af2cp_sTx_c0.hdr.mdata, grant_id});

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic t_ccip_c0_ReqMemHdr mkhdr(input logic [1:0] len, input logic [41:0] addr,
                                                input logic [15:0] md);
      mkhdr         = '0;
      mkhdr.cl_len  = len;
      mkhdr.address = addr;
      mkhdr.mdata   = md;
   endfunction

   task automatic push(input int r, input t_ccip_c0_ReqMemHdr h);
      req_sTx_c0[r].valid = 1'b1;
      req_sTx_c0[r].hdr   = h;
   endtask

   task automatic idle_req();
      for (int i = 0; i < NR; i++) req_sTx_c0[i] = '0;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      c0TxAlmFull = 1'b0;
      idle_req();
      step(2);
      reset = 1'b0;
      iss_q.delete();
   endtask

   task automatic rsp(input logic [3:0] rtype, input logic [15:0] md, input logic [1:0] cl);
      cp2af_sRx_c0               = '0;
      cp2af_sRx_c0.rspValid      = 1'b1;
      cp2af_sRx_c0.hdr.resp_type = rtype;
      cp2af_sRx_c0.hdr.mdata     = md;
      cp2af_sRx_c0.hdr.cl_num    = cl;
      cp2af_sRx_c0.data          = {8{64'hA5A5_0000_0000_0000 | 64'(md)}};
   endtask

   task automatic chk_iss(input string tag, input int n, input int c, input logic [41:0] addr,
                          input logic [15:0] md, input logic [1:0] gid);
      if (n >= iss_q.size()) begin
         chk({tag, "_present"}, 128'(iss_q.size()), 128'(n + 1));
         return;
      end
      chk({tag, "_cyc"}, 128'(iss_q[n].cyc), 128'(c));
      chk({tag, "_addr"}, 128'(iss_q[n].addr), 128'(addr));
      chk({tag, "_mdata"}, 128'(iss_q[n].md), 128'(md));
      chk({tag, "_gid"}, 128'(iss_q[n].gid), 128'(gid));
   endtask

   initial begin
      idle_req();
      cp2af_sRx_c0 = '0;
      do_reset();
      chk("rst_valid", 128'(af2cp_sTx_c0.valid), 0);
      chk("rst_hdr", 128'(af2cp_sTx_c0.hdr), 0);
      chk("rst_almfull", 128'(req_almfull), 0);
      chk("rst_grant", 128'(grant_id), 0);
      for (int i = 0; i < NR; i++) begin
         chk("rst_rspvalid", 128'(req_sRx_c0[i].rspValid), 0);
         chk("rst_rsphdr", 128'(req_sRx_c0[i].hdr), 0);
      end

      // single requester, back-to-back
      t0 = cyc;
      for (int k = 0; k < 4; k++) begin
         push(0, mkhdr(2'd0, 42'(256 + k), 16'(16 + k)));
         step();
      end
      idle_req();
      step(4);
      chk("t1_count", 128'(iss_q.size()), 4);
      for (int k = 0; k < 4; k++) chk_iss("t1", k, t0 + 2 + k, 42'(256 + k), 16'(16 + k), 2'd0);

      // three requesters contend
      do_reset();
      t0 = cyc;
      for (int k = 0; k < 3; k++) begin
         for (int r = 0; r < 3; r++) push(r, mkhdr(2'd0, 42'(r * 16 + k), 16'(k)));
         step();
      end
      idle_req();
      step(12);
      chk("t2_count", 128'(iss_q.size()), 9);
      for (int n = 0; n < 9; n++)
         chk_iss("t2", n, t0 + 2 + n, 42'((n % 3) * 16 + n / 3), {2'(n % 3), 14'(n / 3)}, 2'(n % 3));

      // shared channel almost-full while req1 fills its FIFO
      do_reset();
      c0TxAlmFull = 1'b1;
      t0 = cyc;
      for (int k = 1; k <= 20; k++) begin
         if (k <= 8) push(1, mkhdr(2'd0, 42'(512 + k - 1), 16'(k - 1)));
         else idle_req();
         step();
         chk("t3_almfull", 128'(req_almfull), (k >= 5) ? 128'h2 : 128'h0);
      end
      chk("t3_stalled", 128'(iss_q.size()), 0);
      c0TxAlmFull = 1'b0;
      step(12);
      chk("t3_count", 128'(iss_q.size()), 8);
      for (int n = 0; n < 8; n++) chk_iss("t3", n, t0 + 21 + n, 42'(512 + n), {2'd1, 14'(n)}, 2'd1);
      chk("t3_almfull_end", 128'(req_almfull), 0);

      // response steering by tag
      rsp(4'h0, 16'h8005, 2'd1);
      step();
      for (int i = 0; i < NR; i++) chk("t4a_rspvalid", 128'(req_sRx_c0[i].rspValid), 128'(i == 2));
      chk("t4a_mdata", 128'(req_sRx_c0[2].hdr.mdata), 128'h0005);
      chk("t4a_clnum", 128'(req_sRx_c0[2].hdr.cl_num), 1);
      chk("t4a_data", req_sRx_c0[2].data[127:0], {2{64'hA5A5_0000_0000_8005}});
      rsp(4'h0, 16'h4003, 2'd0);
      step();
      for (int i = 0; i < NR; i++) chk("t4b_rspvalid", 128'(req_sRx_c0[i].rspValid), 128'(i == 1));
      chk("t4b_mdata", 128'(req_sRx_c0[1].hdr.mdata), 128'h0003);
      rsp(4'h4, 16'h4003, 2'd0);
      step();
      for (int i = 0; i < NR; i++) chk("t4c_umsg", 128'(req_sRx_c0[i].rspValid), 0);
      cp2af_sRx_c0 = '0;
      step();

      // reset flushes held FIFOs
      do_reset();
      c0TxAlmFull = 1'b1;
      for (int k = 0; k < 6; k++) begin
         for (int r = 0; r < 3; r++) push(r, mkhdr(2'd0, 42'(768 + r * 16 + k), 16'(k)));
         step();
      end
      idle_req();
      chk("t5_almfull_pre", 128'(req_almfull), 128'h7);
      reset = 1'b1;
      step();
      chk("t5_rst_valid", 128'(af2cp_sTx_c0.valid), 0);
      chk("t5_rst_almfull", 128'(req_almfull), 0);
      reset       = 1'b0;
      c0TxAlmFull = 1'b0;
      iss_q.delete();
      step(4);
      chk("t5_flushed", 128'(iss_q.size()), 0);
      t0 = cyc;
      push(3, mkhdr(2'd0, 42'h3C0, 16'h0007));
      step();
      idle_req();
      step(4);
      chk("t5_count", 128'(iss_q.size()), 1);
      chk_iss("t5", 0, t0 + 2, 42'h3C0, 16'hC007, 2'd3);

`ifdef GLM_C0ARB_INFLIGHT_LIMIT_EN
      // outstanding-line cap of 8 with four-line requests
      do_reset();
      t0 = cyc;
      for (int k = 0; k < 3; k++) begin
         push(0, mkhdr(2'd3, 42'(1024 + 4 * k), 16'(k)));
         step();
      end
      idle_req();
      step(6);
      chk("t6_capped", 128'(iss_q.size()), 2);
      chk_iss("t6a", 0, t0 + 2, 42'd1024, 16'h0000, 2'd0);
      chk_iss("t6b", 1, t0 + 3, 42'd1028, 16'h0001, 2'd0);
      r0 = cyc;
      for (int j = 0; j < 4; j++) begin
         rsp(4'h0, 16'h0000, 2'(j));
         step();
         chk("t6_held", 128'(iss_q.size()), 2);
      end
      cp2af_sRx_c0 = '0;
      step(3);
      chk("t6_count", 128'(iss_q.size()), 3);
      chk_iss("t6c", 2, r0 + 5, 42'd1032, 16'h0002, 2'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
